// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, types and address helper for the frame buffer
package fb_pkg;

  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int COLOR_W = 8;
  localparam int ADDR_W  = 17;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [9:0]         coord_t;

  typedef enum logic {S_ACCEPT, S_PENDING} fb_state_t;

  localparam coord_t FB_W_C = coord_t'(FB_W);
  localparam coord_t FB_H_C = coord_t'(FB_H);
  localparam coord_t ACT_W  = 10'd640;
  localparam coord_t ACT_H  = 10'd480;

  // y*320 + x as shift-add; only valid while FB_W stays 320
  function automatic logic [ADDR_W-1:0] fb_addr(input coord_t y, input coord_t x);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 8) + (yy << 6) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// rtl/frame_buffer_ctrl_if.sv - drawing engine to frame buffer pixel handshake
interface frame_buffer_ctrl_if;
  import fb_pkg::*;

  logic   pix_valid;
  coord_t pix_x;
  coord_t pix_y;
  color_t pix_color;
  logic   frame_done;
  logic   wr_en;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, frame_done,
    input  wr_en
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, frame_done,
    output wr_en
  );

endinterface

// File: rtl/fb_dual_port_ram.sv
// rtl/fb_dual_port_ram.sv - two-bank simple dual-port RAM, registered read
module fb_dual_port_ram #(
  parameter int DATA_W    = 8,
  parameter int BANK_SIZE = 76800,
  parameter int AW        = 18
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 * BANK_SIZE;
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  widx;
  logic [IDX_W-1:0]  ridx;

  // Physical address is {bank, offset}; pack both banks back to back
  assign widx = IDX_W'(waddr[AW-2:0]) + (waddr[AW-1] ? IDX_W'(BANK_SIZE) : '0);
  assign ridx = IDX_W'(raddr[AW-2:0]) + (raddr[AW-1] ? IDX_W'(BANK_SIZE) : '0);

  always_ff @(posedge Clk) begin
    if (we) mem[widx] <= wdata;
    rdata <= mem[ridx];
  end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - double-buffered 320x240 frame store with 2x VGA scan-out
module frame_buffer_ctrl
  import fb_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  frame_buffer_ctrl_if.slave pix,
  input  logic               vga_vblank,
  input  coord_t             vga_x,
  input  coord_t             vga_y,
  output logic               buffer_using,
  output color_t             vga_color,
  output logic [7:0]         swap_count
);

  localparam int PHYS_W = ADDR_W + 1;

  fb_state_t state, state_nx;
  logic      wr_en;
  logic      swap;
  logic      accept;
  logic      pipe_empty;

  logic              s1_valid, s1_in_range, s2_valid, s2_in_range;
  logic [ADDR_W-1:0] s1_addr, s2_addr;
  color_t            s1_color, s2_color;

  logic              rd_active, rd_active2;
  logic [PHYS_W-1:0] rd_addr;
  color_t            rd_data;
  logic              ram_we;

  assign accept     = pix.pix_valid & wr_en;
  assign pipe_empty = ~s1_valid & ~s2_valid;
  assign pix.wr_en  = wr_en;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    swap     = 1'b0;
    case (state)
      S_ACCEPT: begin
        wr_en = 1'b1;
        if (pix.frame_done) state_nx = S_PENDING;
      end
      S_PENDING: begin
        if (vga_vblank && pipe_empty) begin
          swap     = 1'b1;
          state_nx = S_ACCEPT;
        end
      end
      default: state_nx = S_ACCEPT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= S_ACCEPT;
      buffer_using <= 1'b0;
      swap_count   <= 8'd0;
    end else begin
      state <= state_nx;
      if (swap) begin
        buffer_using <= ~buffer_using;
        swap_count   <= swap_count + 8'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge Clk) begin
    s1_in_range <= (pix.pix_x < FB_W_C) && (pix.pix_y < FB_H_C);
    s1_addr     <= fb_addr(pix.pix_y, pix.pix_x);
    s1_color    <= pix.pix_color;
    s2_in_range <= s1_in_range;
    s2_addr     <= s1_addr;
    s2_color    <= s1_color;
  end

  // Gate with Reset so a write sitting in stage 2 at reset never lands
  assign ram_we = s2_valid & s2_in_range & ~Reset;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_active  <= 1'b0;
      rd_active2 <= 1'b0;
    end else begin
      rd_active  <= (vga_x < ACT_W) && (vga_y < ACT_H);
      rd_active2 <= rd_active;
    end
  end

  always_ff @(posedge Clk) begin
    if ((vga_x < ACT_W) && (vga_y < ACT_H))
      rd_addr <= {buffer_using, fb_addr(vga_y >> 1, vga_x >> 1)};
    else
      rd_addr <= {buffer_using, {ADDR_W{1'b0}}};
  end

  fb_dual_port_ram #(
    .DATA_W   (COLOR_W),
    .BANK_SIZE(FB_W * FB_H),
    .AW       (PHYS_W)
  ) u_ram (
    .Clk  (Clk),
    .we   (ram_we),
    .waddr({~buffer_using, s2_addr}),
    .wdata(s2_color),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign vga_color = rd_active2 ? rd_data : '0;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - directed self-checking bench for frame_buffer_ctrl
module tb_frame_buffer_ctrl;
  import fb_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       vga_vblank = 1'b0;
  coord_t     vga_x = 10'd700;
  coord_t     vga_y = 10'd100;
  logic       buffer_using;
  color_t     vga_color;
  logic [7:0] swap_count;

  int total = 0;
  int bad = 0;

  frame_buffer_ctrl_if pif ();

  frame_buffer_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix         (pif),
    .vga_vblank  (vga_vblank),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .buffer_using(buffer_using),
    .vga_color   (vga_color),
    .swap_count  (swap_count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_pix(input logic v, input coord_t x, input coord_t y,
                         input color_t c, input logic fd);
    pif.pix_valid  = v;
    pif.pix_x      = x;
    pif.pix_y      = y;
    pif.pix_color  = c;
    pif.frame_done = fd;
  endtask

  task automatic set_vga(input coord_t x, input coord_t y);
    vga_x = x;
    vga_y = y;
  endtask

  coord_t wx [5] = '{10'd320, 10'd0, 10'd0, 10'd320, 10'd9};
  coord_t wy [5] = '{10'd0,   10'd1, 10'd2, 10'd1,   10'd9};
  color_t wc [5] = '{8'hFF,   8'h07, 8'h11, 8'hEE,   8'h24};

  initial begin
    int wr_bad;
    int w;

    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b0);
    cyc(3);
    chk("rst_buffer_using", buffer_using, 0);
    chk("rst_wr_en", pif.wr_en, 1);
    chk("rst_vga_color", vga_color, 0);
    chk("rst_swap_count", swap_count, 0);
    Reset = 1'b0;
    cyc(1);

    // Frame 1: one pixel into bank 1, swap held off until vblank
    set_pix(1'b1, 10'd5, 10'd3, 8'h3F, 1'b0);
    cyc(1);
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b1);
    cyc(1);
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b0);
    wr_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (pif.wr_en !== 1'b0 || buffer_using !== 1'b0) wr_bad++;
      cyc(1);
    end
    chk("pending_wr_en_low_100", wr_bad, 0);
    chk("pending_swap_count", swap_count, 0);
    vga_vblank = 1'b1;
    cyc(1);
    chk("swap1_buffer_using", buffer_using, 1);
    chk("swap1_swap_count", swap_count, 1);
    chk("swap1_wr_en", pif.wr_en, 1);
    vga_vblank = 1'b0;

    set_vga(10'd10, 10'd6);
    cyc(1);
    chk("rd_not_after_1", vga_color, 0);
    set_vga(10'd11, 10'd7);
    cyc(1);
    chk("rd_10_6", vga_color, 8'h3F);
    set_vga(10'd650, 10'd4);
    cyc(1);
    chk("rd_11_7", vga_color, 8'h3F);
    set_vga(10'd700, 10'd100);
    cyc(1);
    chk("rd_650_4_blank", vga_color, 0);
    cyc(1);
    chk("rd_700_100_blank", vga_color, 0);

    // Frame 2 into bank 0, out-of-range pixels aliasing in-range addresses
    for (int i = 0; i < 5; i++) begin
      set_pix(1'b1, wx[i], wy[i], wc[i], 1'b0);
      cyc(1);
    end
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b1);
    cyc(1);
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b0);
    vga_vblank = 1'b1;
    w = 0;
    while (buffer_using !== 1'b0 && w < 20) begin
      cyc(1);
      w++;
    end
    chk("swap2_buffer_using", buffer_using, 0);
    chk("swap2_swap_count", swap_count, 2);
    vga_vblank = 1'b0;

    set_vga(10'd0, 10'd2);
    cyc(1);
    set_vga(10'd0, 10'd4);
    cyc(1);
    chk("rd_0_2_oob_dropped", vga_color, 8'h07);
    set_vga(10'd18, 10'd18);
    cyc(1);
    chk("rd_0_4_oob_dropped", vga_color, 8'h11);
    set_vga(10'd700, 10'd100);
    cyc(1);
    chk("rd_18_18", vga_color, 8'h24);

    // Frame 3: pixel with frame_done during vblank, swap after drain
    vga_vblank = 1'b1;
    set_pix(1'b1, 10'd7, 10'd8, 8'h5A, 1'b1);
    cyc(1);
    chk("drain_wr_en_low", pif.wr_en, 0);
    chk("drain_no_swap_c1", buffer_using, 0);
    set_pix(1'b1, 10'd7, 10'd8, 8'h99, 1'b1);
    cyc(1);
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b0);
    chk("drain_no_swap_c2", buffer_using, 0);
    cyc(1);
    chk("drain_no_swap_c3", buffer_using, 0);
    cyc(1);
    chk("swap3_buffer_using", buffer_using, 1);
    chk("swap3_swap_count", swap_count, 3);
    chk("swap3_wr_en", pif.wr_en, 1);
    vga_vblank = 1'b0;
    set_vga(10'd14, 10'd16);
    cyc(2);
    chk("rd_14_16_pending_ignored", vga_color, 8'h5A);
    set_vga(10'd700, 10'd100);

    // Reset with a write in stage 2 aimed at bank 0
    set_pix(1'b1, 10'd9, 10'd9, 8'hC3, 1'b1);
    cyc(1);
    set_pix(1'b0, 10'd0, 10'd0, 8'h00, 1'b0);
    cyc(1);
    Reset = 1'b1;
    cyc(1);
    chk("rst2_buffer_using", buffer_using, 0);
    chk("rst2_swap_count", swap_count, 0);
    chk("rst2_vga_color", vga_color, 0);
    Reset = 1'b0;
    cyc(1);
    chk("rst2_wr_en_next", pif.wr_en, 1);
    set_vga(10'd18, 10'd18);
    cyc(2);
    chk("rst2_inflight_dropped", vga_color, 8'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
Double-buffered frame store that sits directly downstream of the drawing engine.
- Accepts one pixel write per cycle (x, y, 8-bit colour) into the back buffer and tells the engine when it may write (wr_en) and which bank is on screen (buffer_using).
- Swaps front and back banks during VGA vertical blank once the engine signals frame completion.
- Serves the VGA scan-out with 2x upscaling from a 320x240 store to 640x480.

Parameters:
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- COLOR_W, 8, colour bits per pixel.
- ADDR_W, 17, per-bank address width; must satisfy 2^ADDR_W >= FB_W*FB_H.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  the engine presents a pixel this cycle.
- pix_x  in  10  pixel x in framebuffer space.
- pix_y  in  10  pixel y in framebuffer space.
- pix_color  in  COLOR_W  pixel colour.
- frame_done  in  1  single-cycle pulse: the engine has finished the back-buffer frame.
- vga_vblank  in  1  level, high during VGA vertical blank.
- vga_x  in  10  scan-out x, 0..799.
- vga_y  in  10  scan-out y, 0..524.
- wr_en  out  1  ready: the back buffer accepts pixels.
- buffer_using  out  1  bank currently displayed (front).
- vga_color  out  COLOR_W  pixel colour for (vga_x, vga_y).
- swap_count  out  8  number of completed swaps, wraps modulo 256.

Behaviour:
Reset values:
- buffer_using=0, wr_en=1, vga_color=0, swap_count=0.
- FSM enters S_ACCEPT.
- Write-pipeline valid bits are cleared, so in-flight writes are dropped.
- RAM contents are not cleared.

FSM states:
- S_ACCEPT: wr_en=1.
  - frame_done moves the FSM to S_PENDING next cycle.
  - A pix_valid in the same cycle as frame_done is accepted and belongs to the finishing frame.
- S_PENDING: wr_en=0; pix_valid is ignored; further frame_done pulses are ignored.
  - Swap condition: vga_vblank=1 AND write pipeline empty.
  - On the swap cycle: buffer_using toggles, swap_count increments, FSM returns to S_ACCEPT (wr_en=1 the next cycle).
  - If vblank ends before the pipeline drains, wait for the next vblank.

Write path (accept = pix_valid & wr_en):
- Stage 1 registers:
  - the in-range flag: pix_x < FB_W and pix_y < FB_H;
  - the address pix_y*FB_W + pix_x, computed as (y<<8)+(y<<6)+x for the default FB_W;
  - the colour.
- Stage 2 issues the RAM write to bank ~buffer_using, physical address {~buffer_using, addr}.
- Latency: 2 cycles from accept to RAM write.
- Out-of-range pixels complete the handshake but are never written.
- The pipeline is empty when both stage valid bits are 0.

Read path:
- Cycle 0: register active = (vga_x<640 && vga_y<480) and address (vga_y>>1)*FB_W + (vga_x>>1) in bank buffer_using.
- Cycle 1: RAM synchronous read.
- Cycle 2: vga_color = data if active, else 0.
- Latency: exactly 2 cycles.
- buffer_using is sampled at cycle 0; a swap mid-read completes from the old bank.

Port contention:
- Read and write always target opposite banks, so there is no conflict.
- The RAM is simple dual-port: one write port, one read port.

Decomposition:
- Package fb_pkg:
  - FB_W, FB_H, COLOR_W, ADDR_W constants.
  - typedef color_t (logic [COLOR_W-1:0]).
  - enum fb_state_t {S_ACCEPT, S_PENDING}.
  - Active-area constants 640 and 480.
- Sub-module fb_dual_port_ram: depth 2*FB_W*FB_H, COLOR_W wide, one synchronous write port, one synchronous read port with registered output; infers M9K blocks.

Test Plan:
1. Reset -> buffer_using=0, wr_en=1, vga_color=0, swap_count=0.
2. Write (5,3,0x3F) with pix_valid, then frame_done; hold vga_vblank=0 for 100 cycles.
   - wr_en=0 throughout.
   - Raise vblank -> next cycle buffer_using=1, swap_count=1, wr_en=1.
   - Drive vga (10,6) and (11,7) -> vga_color=0x3F exactly 2 cycles later.
3. pix_valid at (320,0,0xFF), then a valid write at (0,1,0x07); swap -> vga (0,2)=0x07.
   - The read at address 320, i.e. framebuffer (0,1), must show 0x07, not 0xFF.
4. pix_valid and frame_done in the same cycle, with vga_vblank already 1.
   - The pixel is written.
   - The swap occurs only after a 2-cycle drain, no earlier.
5. vga (700,100) -> vga_color=0 after 2 cycles regardless of RAM contents.
6. Assert Reset while in S_PENDING with a write in flight.
   - The in-flight write never lands.
   - All reset values hold, including buffer_using=0.
   - Next cycle wr_en=1.
